// File: rtl/gate_test_pkg.sv
// Shared definitions for the AND gate truth-table sequencer.
//   state_t  : sequencer FSM encoding (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3)
//   MaxNIn   : largest supported number of gate inputs
//   exp_and  : expected AND of the low `width` bits of a vector
package gate_test_pkg;

    localparam int unsigned MaxNIn = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } state_t;

    function automatic logic exp_and(input logic [MaxNIn-1:0] vec, input int unsigned width);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < MaxNIn; i++) begin
            if (i < width) r = r & vec[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter with a zero flag, used to time the vector settle window.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (count cleared to 0)
//   load     : load load_val (takes priority over dec)
//   load_val : value to load
//   dec      : decrement by one
//   zero     : count is zero
module settle_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/and_truth_sequencer.sv
// Clocked stimulus/check stage for a combinational AND gate. On start it walks
// vec_out through all 2^N_IN vectors in ascending order, holds each for SETTLE
// cycles, samples gate_in for one cycle and counts mismatches against &vec_out.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : run request (ignored while busy)
//   gate_in    : output of the gate under test
//   vec_out    : vector driven to the gate under test
//   busy       : run in progress
//   done       : run finished, held until next start
//   pass       : valid with done, 1 = no mismatches
//   err_cnt    : mismatch count of current/last run
//   result_map : sampled gate_in per vector
// Build option: define AND_TRUTH_LOG_EN to record result_map; otherwise it is tied to 0.
module and_truth_sequencer
    import gate_test_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 gate_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_cnt,
    output logic [2**N_IN-1:0]   result_map
);

    localparam int unsigned     CntW    = $clog2(SETTLE) + 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VecLast = '1;

    state_t          state_q;
    logic [N_IN-1:0] vec_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [N_IN:0]   err_q;

    logic            run_start;
    logic            last_vec;
    logic            mismatch;
    logic [N_IN:0]   err_nxt;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_zero;

    always_comb begin
        run_start = ((state_q == StIdle) || (state_q == StDone)) && start;
        last_vec  = (vec_q == VecLast);
        mismatch  = (gate_in != exp_and(MaxNIn'(vec_q), N_IN));
        err_nxt   = err_q + (N_IN + 1)'(mismatch);
        cnt_load  = run_start || ((state_q == StSample) && !last_vec);
        cnt_dec   = (state_q == StSettle) && !cnt_zero;
    end

    settle_counter #(
        .WIDTH (CntW)
    ) u_settle_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CntLoad),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StSettle;
                        vec_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                    end
                end
                StSettle: begin
                    if (cnt_zero) state_q <= StSample;
                end
                StSample: begin
                    err_q <= err_nxt;
                    if (last_vec) begin
                        // vec_out stays at all-ones while DONE
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_nxt == '0);
                    end else begin
                        state_q <= StSettle;
                        vec_q   <= vec_q + N_IN'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign vec_out = vec_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;

`ifdef AND_TRUTH_LOG_EN
    logic [2**N_IN-1:0] map_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_q <= '0;
        end else if (run_start) begin
            map_q <= '0;
        end else if (state_q == StSample) begin
            map_q[vec_q] <= gate_in;
        end
    end

    assign result_map = map_q;
`else
    assign result_map = '0;
`endif

endmodule
